control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: processor clock (the divided clock), all state changes on its rising edge.
REQ-003 Port clr, input, 1 bit: clear/reset, sampled on the rising edge of clk.
REQ-004 Port opcode, input, 6 bits: instruction bits 31:26 from the instruction register.
REQ-005 Port funct, input, 6 bits: instruction bits 5:0 from the instruction register.
REQ-006 Port F_zero, input, 1 bit: ALU zero flag, combinational from the datapath.
REQ-007 Port F_overflow, input, 1 bit: ALU overflow flag, combinational from the datapath.
REQ-008 Ports write, pc_inc, pc_ld, ir_ld, dmu_wen, mux_a, mux_b and mux_im_1 are 1-bit outputs with the datapath meanings of the same names.
REQ-009 Port mux_data, output, 2 bits: data-bus source, 00 = PC, 01 = memory, 10 = ALU.
REQ-010 Port mux_im_2, output, 2 bits: ALU input B source, 00 = reg B, 01 = LZE immediate, 10 = all-ones.
REQ-011 Port alu_op, output, 3 bits: ALU operation code.
REQ-012 Port state, output, 4 bits: current state encoding, exposed for debug.
REQ-013 Port halt, output, 1 bit: high while in TRAP.

Function
REQ-014 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB=6, BRANCH=7, JUMP=8, TRAP=15.
REQ-015 In FETCH the block SHALL drive mux_data=01, ir_ld=1, pc_inc=1, then go to DECODE.
REQ-016 In DECODE the block SHALL latch opcode and funct into internal registers; all later states SHALL use only the latched copies.
REQ-017 DECODE SHALL go to EXEC on opcode 0x00, 0x08, 0x0C, 0x0D or 0x0F; to ADDR on 0x23 or 0x2B; to BRANCH on 0x04; to JUMP on 0x02; otherwise to TRAP.
REQ-018 alu_op encoding SHALL be AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-019 For R-type, funct 0x20/0x22/0x24/0x25/0x2A SHALL map to ADD/SUB/AND/OR/SLT; any other funct SHALL go from EXEC to TRAP.
REQ-020 EXEC, R-type: mux_im_1=0, mux_im_2=00.
REQ-021 EXEC, addi/andi/ori: mux_im_1=0, mux_im_2=01, alu_op ADD/AND/OR respectively.
REQ-022 EXEC, lui: mux_im_1=1, mux_im_2=10, alu_op=AND.
REQ-023 EXEC SHALL go to TRAP if F_overflow=1 for ADD/SUB/addi; otherwise it SHALL go to WB.
REQ-024 In WB the block SHALL drive mux_data=10 and write=1, then go to FETCH.
REQ-025 In ADDR the block SHALL drive alu_op=ADD and mux_im_2=01, then go to MEM_RD on opcode 0x23 or MEM_WR on opcode 0x2B.
REQ-026 In MEM_RD the block SHALL drive mux_data=01 and write=1, then go to FETCH.
REQ-027 In MEM_WR the block SHALL drive dmu_wen=1, then go to FETCH.
REQ-028 In BRANCH the block SHALL drive alu_op=SUB and pc_ld=F_zero (combinational in-state), then go to FETCH.
REQ-029 In JUMP the block SHALL drive pc_ld=1, then go to FETCH.
REQ-030 TRAP SHALL be absorbing until clr, with halt=1 and all other control outputs 0.
REQ-031 Every output not named for a state SHALL be 0 in that state.
REQ-032 write, dmu_wen, pc_ld and pc_inc SHALL never be high in the same cycle as each other, except pc_inc with ir_ld in FETCH.
REQ-033 Instruction latency from FETCH to the next FETCH SHALL be 4 cycles for R-type, I-type ALU, lw and sw, and 3 cycles for beq and j.

Reset
REQ-034 While clr=1, all outputs SHALL be forced to 0 combinationally, including state and halt.
REQ-035 At a clock edge with clr=1, the next state SHALL be FETCH and the latched opcode/funct SHALL be 0.
REQ-036 clr asserted in any state, including TRAP and mid-instruction, SHALL abort the instruction with no write or dmu_wen in the following cycle.

Verification
REQ-037 Release clr, opcode=0x00, funct=0x20, F_overflow=0 -> states 0,1,2,6,0; write=1 only in WB with mux_data=10 and alu_op=010.
REQ-038 Run lw (0x23) then sw (0x2B) -> lw passes 0,1,3,4 with write=1 and mux_data=01 in state 4; sw passes 0,1,3,5 with dmu_wen=1 in state 5 only.
REQ-039 Run beq (0x04) with F_zero=1, then with F_zero=0 -> pc_ld=1 in BRANCH for the first; pc_ld=0 throughout for the second; each takes 3 cycles.
REQ-040 Run addi with F_overflow=1 in EXEC -> TRAP, halt=1, write never asserted; halt stays high for 10+ cycles; clr returns the block to FETCH.
REQ-041 Run opcode 0x3F, then opcode 0x00 with funct 0x01 -> each reaches TRAP, halt=1.
REQ-042 Change opcode after DECODE during a lui -> EXEC still drives mux_im_1=1, mux_im_2=10, alu_op=000.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
//   Multicycle Moore controller for a small MIPS-style datapath.
//   Steps through FETCH / DECODE / execute states and drives the datapath
//   mux selects, ALU opcode and write strobes from the current state.
//
// Ports
//   clk          processor clock, all state changes on its rising edge
//   clr          synchronous active-high clear; also forces every output low
//   opcode       instruction bits 31:26 (live from the instruction register)
//   funct        instruction bits 5:0   (live from the instruction register)
//   F_zero       ALU zero flag
//   F_overflow   ALU overflow flag
//   write        register-file write strobe
//   pc_inc       PC increment
//   pc_ld        PC load
//   ir_ld        instruction register load
//   dmu_wen      data memory write enable
//   mux_a/mux_b  datapath selects, unused by this instruction set (held low)
//   mux_im_1     immediate path select for lui
//   mux_data     data-bus source: 00 PC, 01 memory, 10 ALU
//   mux_im_2     ALU B source: 00 reg B, 01 LZE immediate, 10 all-ones
//   alu_op       ALU operation
//   state        current state encoding (debug)
//   halt         high while trapped
//
// state  | meaning
// FETCH  | read instruction into IR, increment PC
// DECODE | latch opcode/funct, pick the execute path
// EXEC   | ALU operation for R-type / immediate instructions
// ADDR   | effective address for lw / sw
// MEM_RD | load data from memory into the register file
// MEM_WR | store register data to memory
// WB     | write ALU result to the register file
// BRANCH | beq compare, load PC when equal
// JUMP   | load PC with jump target
// TRAP   | illegal instruction or overflow, held until clr

module control_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       F_zero,
  input  logic       F_overflow,
  output logic       write,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       dmu_wen,
  output logic       mux_a,
  output logic       mux_b,
  output logic       mux_im_1,
  output logic [1:0] mux_data,
  output logic [1:0] mux_im_2,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       halt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] fn_q;

  // ALU setup for the EXEC/WB path, derived only from the latched instruction
  logic [2:0] ex_alu_op;
  logic       ex_im_1;
  logic [1:0] ex_im_2;
  logic       ex_legal;
  logic       ex_ovf_chk;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    ex_alu_op  = ALU_AND;
    ex_im_1    = 1'b0;
    ex_im_2    = 2'b00;
    ex_legal   = 1'b0;
    ex_ovf_chk = 1'b0;
    case (op_q)
      OP_RTYPE: begin
        ex_legal = 1'b1;
        case (fn_q)
          FN_ADD: begin ex_alu_op = ALU_ADD; ex_ovf_chk = 1'b1; end
          FN_SUB: begin ex_alu_op = ALU_SUB; ex_ovf_chk = 1'b1; end
          FN_AND: ex_alu_op = ALU_AND;
          FN_OR:  ex_alu_op = ALU_OR;
          FN_SLT: ex_alu_op = ALU_SLT;
          default: ex_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ex_legal   = 1'b1;
        ex_alu_op  = ALU_ADD;
        ex_im_2    = 2'b01;
        ex_ovf_chk = 1'b1;
      end
      OP_ANDI: begin
        ex_legal  = 1'b1;
        ex_alu_op = ALU_AND;
        ex_im_2   = 2'b01;
      end
      OP_ORI: begin
        ex_legal  = 1'b1;
        ex_alu_op = ALU_OR;
        ex_im_2   = 2'b01;
      end
      OP_LUI: begin
        // all-ones AND the shifted immediate passes the upper half through
        ex_legal  = 1'b1;
        ex_alu_op = ALU_AND;
        ex_im_1   = 1'b1;
        ex_im_2   = 2'b10;
      end
      default: ex_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        if (!ex_legal || (ex_ovf_chk && F_overflow)) state_d = S_TRAP;
        else                                          state_d = S_WB;
      end
      S_ADDR:   state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    write    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    dmu_wen  = 1'b0;
    mux_a    = 1'b0;
    mux_b    = 1'b0;
    mux_im_1 = 1'b0;
    mux_data = 2'b00;
    mux_im_2 = 2'b00;
    alu_op   = 3'b000;
    halt     = 1'b0;
    state    = state_q;
    case (state_q)
      S_FETCH: begin
        mux_data = 2'b01;
        ir_ld    = 1'b1;
        pc_inc   = 1'b1;
      end
      S_EXEC: begin
        mux_im_1 = ex_im_1;
        mux_im_2 = ex_im_2;
        alu_op   = ex_alu_op;
      end
      S_WB: begin
        // ALU is combinational: keep its setup so the result stays valid while written
        mux_data = 2'b10;
        write    = 1'b1;
        mux_im_1 = ex_im_1;
        mux_im_2 = ex_im_2;
        alu_op   = ex_alu_op;
      end
      S_ADDR: begin
        alu_op   = ALU_ADD;
        mux_im_2 = 2'b01;
      end
      S_MEM_RD: begin
        mux_data = 2'b01;
        write    = 1'b1;
      end
      S_MEM_WR: dmu_wen = 1'b1;
      S_BRANCH: begin
        alu_op = ALU_SUB;
        pc_ld  = F_zero;
      end
      S_JUMP:  pc_ld = 1'b1;
      S_TRAP:  halt  = 1'b1;
      default: ;
    endcase
    if (clr) begin
      write    = 1'b0;
      pc_inc   = 1'b0;
      pc_ld    = 1'b0;
      ir_ld    = 1'b0;
      dmu_wen  = 1'b0;
      mux_a    = 1'b0;
      mux_b    = 1'b0;
      mux_im_1 = 1'b0;
      mux_data = 2'b00;
      mux_im_2 = 2'b00;
      alu_op   = 3'b000;
      halt     = 1'b0;
      state    = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic [5:0] opcode, funct;
  logic       F_zero, F_overflow;
  logic       write, pc_inc, pc_ld, ir_ld, dmu_wen, mux_a, mux_b, mux_im_1;
  logic [1:0] mux_data, mux_im_2;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       halt;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .opcode(opcode), .funct(funct),
    .F_zero(F_zero), .F_overflow(F_overflow),
    .write(write), .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_ld(ir_ld),
    .dmu_wen(dmu_wen), .mux_a(mux_a), .mux_b(mux_b), .mux_im_1(mux_im_1),
    .mux_data(mux_data), .mux_im_2(mux_im_2), .alu_op(alu_op),
    .state(state), .halt(halt)
  );

  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  // word layout: {state[19:16], halt, write, pc_inc, pc_ld, ir_ld, dmu_wen,
  //               mux_a, mux_b, mux_im_1, mux_data[6:5], mux_im_2[4:3], alu_op[2:0]}
  function automatic logic [19:0] w(input logic [3:0] st, input logic hl, wr, pci, pcl,
                                    irl, dmu, im1, input logic [1:0] md, im2,
                                    input logic [2:0] alu);
    return {st, hl, wr, pci, pcl, irl, dmu, 1'b0, 1'b0, im1, md, im2, alu};
  endfunction

  function automatic logic [19:0] obs_now();
    return {state, halt, write, pc_inc, pc_ld, ir_ld, dmu_wen, mux_a, mux_b,
            mux_im_1, mux_data, mux_im_2, alu_op};
  endfunction

  function automatic logic [19:0] trap_w();
    return w(4'hF, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] got, want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, want);
    end
  endtask

  task automatic cycle(input logic c, input logic [5:0] o, f, input logic z, v,
                       input logic [19:0] exp, input string nm, input int idx,
                       output logic [19:0] got);
    @(negedge clk);
    clr = c; opcode = o; funct = f; F_zero = z; F_overflow = v;
    #1;
    got = obs_now();
    check(nm, idx, 32'(got), 32'(exp));
  endtask

  // Expected per-cycle output trace of one instruction, FETCH up to the cycle
  // before the next FETCH (or up to the first TRAP cycle).
  task automatic model_trace(input logic [5:0] op, fn, input logic zf, ovf);
    logic [2:0] alu;
    logic [1:0] im2;
    logic im1, legal, ovf_traps;
    exp_q.delete();
    exp_q.push_back(w(4'd0, 0, 0, 1, 0, 1, 0, 0, 2'b01, 2'b00, 3'b000));
    exp_q.push_back(w(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000));
    alu = 3'b000; im2 = 2'b00; im1 = 0; legal = 1; ovf_traps = 0;
    case (op)
      6'h23: begin
        exp_q.push_back(w(4'd3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b010));
        exp_q.push_back(w(4'd4, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000));
      end
      6'h2B: begin
        exp_q.push_back(w(4'd3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b010));
        exp_q.push_back(w(4'd5, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000));
      end
      6'h04: exp_q.push_back(w(4'd7, 0, 0, 0, zf, 0, 0, 0, 2'b00, 2'b00, 3'b110));
      6'h02: exp_q.push_back(w(4'd8, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000));
      6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        if (op == 6'h00) begin
          case (fn)
            6'h20: begin alu = 3'b010; ovf_traps = 1; end
            6'h22: begin alu = 3'b110; ovf_traps = 1; end
            6'h24: alu = 3'b000;
            6'h25: alu = 3'b001;
            6'h2A: alu = 3'b111;
            default: legal = 0;
          endcase
        end else if (op == 6'h08) begin alu = 3'b010; im2 = 2'b01; ovf_traps = 1; end
        else if (op == 6'h0C) begin alu = 3'b000; im2 = 2'b01; end
        else if (op == 6'h0D) begin alu = 3'b001; im2 = 2'b01; end
        else begin alu = 3'b000; im1 = 1; im2 = 2'b10; end
        exp_q.push_back(w(4'd2, 0, 0, 0, 0, 0, 0, im1, 2'b00, im2, alu));
        if (!legal || (ovf_traps && ovf)) exp_q.push_back(trap_w());
        else exp_q.push_back(w(4'd6, 0, 1, 0, 0, 0, 0, im1, 2'b10, im2, alu));
      end
      default: exp_q.push_back(trap_w());
    endcase
  endtask

  // Runs one instruction. Opcode/funct are valid only in FETCH/DECODE; later
  // cycles see jop/jfn. abort_at>=0 asserts clr in that cycle instead.
  task automatic run_instr(input logic [5:0] op, fn, input logic zf, ovf,
                           input logic [5:0] jop, jfn, input int abort_at, input string nm,
                           output logic [19:0] sts, output int len, output int nw,
                           output int nd, output int npl, output logic trapped);
    logic [19:0] got;
    logic [5:0] o, f;
    logic z, v;
    model_trace(op, fn, zf, ovf);
    sts = '0; len = 0; nw = 0; nd = 0; npl = 0; trapped = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < 2) ? op : jop;
      f = (i < 2) ? fn : jfn;
      z = (i == 2) ? zf : 1'($urandom);
      v = (i == 2) ? ovf : 1'($urandom);
      if (i == abort_at) begin
        cycle(1'b1, o, f, z, v, 20'h0, {nm, "/clr"}, i, got);
        return;
      end
      cycle(1'b0, o, f, z, v, exp_q[i], nm, i, got);
      sts = {sts[15:0], got[19:16]};
      len++;
      nw  += int'(got[14]);
      nd  += int'(got[10]);
      npl += int'(got[12]);
      if (got[15]) trapped = 1;
    end
    if (exp_q[exp_q.size()-1][19:16] == 4'hF) begin
      for (int k = 0; k < 10; k++)
        cycle(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
              trap_w(), {nm, "/hold"}, k, got);
      cycle(1'b1, 6'($urandom), 6'($urandom), 1'b1, 1'b1, 20'h0, {nm, "/clrtrap"}, 0, got);
    end
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zf;
    logic        ovf;
    logic [5:0]  jop;
    logic [5:0]  jfn;
    logic [19:0] sts;
    logic [3:0]  len;
    logic [3:0]  nw;
    logic [3:0]  nd;
    logic [3:0]  npl;
    logic        trap;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    logic [19:0] got, sts;
    int len, nw, nd, npl;
    logic trapped;
    logic [5:0] op, fn;
    logic [5:0] ops[9];
    logic [5:0] fns[5];

    //                op     fn     zf ovf  jop    jfn    states     len nw nd pl trap
    tbl[0]  = '{6'h00, 6'h20, 0, 0, 6'h23, 6'h22, 20'h00126, 4, 1, 0, 0, 0}; // add
    tbl[1]  = '{6'h00, 6'h22, 0, 0, 6'h00, 6'h20, 20'h00126, 4, 1, 0, 0, 0}; // sub
    tbl[2]  = '{6'h00, 6'h24, 0, 0, 6'h3F, 6'h01, 20'h00126, 4, 1, 0, 0, 0}; // and
    tbl[3]  = '{6'h00, 6'h25, 0, 0, 6'h04, 6'h2A, 20'h00126, 4, 1, 0, 0, 0}; // or
    tbl[4]  = '{6'h00, 6'h2A, 0, 1, 6'h08, 6'h20, 20'h00126, 4, 1, 0, 0, 0}; // slt ignores ovf
    tbl[5]  = '{6'h23, 6'h00, 0, 0, 6'h2B, 6'h00, 20'h00134, 4, 1, 0, 0, 0}; // lw
    tbl[6]  = '{6'h2B, 6'h00, 0, 0, 6'h23, 6'h00, 20'h00135, 4, 0, 1, 0, 0}; // sw
    tbl[7]  = '{6'h04, 6'h00, 1, 0, 6'h02, 6'h00, 20'h00017, 3, 0, 0, 1, 0}; // beq taken
    tbl[8]  = '{6'h04, 6'h00, 0, 0, 6'h02, 6'h00, 20'h00017, 3, 0, 0, 0, 0}; // beq not taken
    tbl[9]  = '{6'h02, 6'h00, 0, 0, 6'h04, 6'h00, 20'h00018, 3, 0, 0, 1, 0}; // j
    tbl[10] = '{6'h08, 6'h00, 0, 1, 6'h0C, 6'h00, 20'h0012F, 4, 0, 0, 0, 1}; // addi overflow
    tbl[11] = '{6'h3F, 6'h20, 0, 0, 6'h00, 6'h20, 20'h0001F, 3, 0, 0, 0, 1}; // illegal opcode
    tbl[12] = '{6'h00, 6'h01, 0, 0, 6'h00, 6'h20, 20'h0012F, 4, 0, 0, 0, 1}; // illegal funct
    tbl[13] = '{6'h0F, 6'h00, 0, 0, 6'h00, 6'h20, 20'h00126, 4, 1, 0, 0, 0}; // lui, opcode changes
    tbl[14] = '{6'h00, 6'h22, 0, 1, 6'h00, 6'h24, 20'h0012F, 4, 0, 0, 0, 1}; // sub overflow
    tbl[15] = '{6'h0C, 6'h00, 0, 1, 6'h08, 6'h00, 20'h00126, 4, 1, 0, 0, 0}; // andi ignores ovf
    tbl[16] = '{6'h0D, 6'h00, 0, 0, 6'h0F, 6'h00, 20'h00126, 4, 1, 0, 0, 0}; // ori
    tbl[17] = '{6'h08, 6'h00, 0, 0, 6'h00, 6'h22, 20'h00126, 4, 1, 0, 0, 0}; // addi

    clr = 1'b1; opcode = 6'h00; funct = 6'h20; F_zero = 1'b1; F_overflow = 1'b1;

    // outputs forced low while clr is held, whatever the inputs
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 6'($urandom), 6'($urandom), 1'b1, 1'b1, 20'h0, "reset", k, got);

    for (int i = 0; i < NV; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].zf, tbl[i].ovf, tbl[i].jop, tbl[i].jfn,
                -1, "vec", sts, len, nw, nd, npl, trapped);
      check("vec_states", i, 32'(sts), 32'(tbl[i].sts));
      check("vec_len", i, 32'(len), 32'(tbl[i].len));
      check("vec_nwrite", i, 32'(nw), 32'(tbl[i].nw));
      check("vec_ndmu", i, 32'(nd), 32'(tbl[i].nd));
      check("vec_npcld", i, 32'(npl), 32'(tbl[i].npl));
      check("vec_trap", i, 32'(trapped), 32'(tbl[i].trap));
    end

    // clr mid-instruction: ADDR of sw, MEM_WR, WB of add, MEM_RD, FETCH; the
    // following instruction's first cycle must be a clean FETCH
    run_instr(6'h2B, 6'h00, 0, 0, 6'h2B, 6'h00, 2, "abort_addr", sts, len, nw, nd, npl, trapped);
    run_instr(6'h2B, 6'h00, 0, 0, 6'h2B, 6'h00, 3, "abort_memwr", sts, len, nw, nd, npl, trapped);
    run_instr(6'h00, 6'h20, 0, 0, 6'h00, 6'h20, 3, "abort_wb", sts, len, nw, nd, npl, trapped);
    run_instr(6'h23, 6'h00, 0, 0, 6'h23, 6'h00, 3, "abort_memrd", sts, len, nw, nd, npl, trapped);
    run_instr(6'h04, 6'h00, 1, 0, 6'h04, 6'h00, 2, "abort_br", sts, len, nw, nd, npl, trapped);
    run_instr(6'h00, 6'h20, 0, 0, 6'h00, 6'h20, 0, "abort_fetch", sts, len, nw, nd, npl, trapped);

    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int n = 0; n < 300; n++) begin
      int sel, ab;
      sel = int'($urandom_range(0, 10));
      op  = (sel < 9) ? ops[sel] : 6'($urandom);
      fn  = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(op, fn, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
                ab, "rand", sts, len, nw, nd, npl, trapped);
    end

    // confirms the block leaves the last random instruction in a clean state
    run_instr(6'h00, 6'h20, 0, 0, 6'h00, 6'h22, -1, "final", sts, len, nw, nd, npl, trapped);
    check("final_states", 0, 32'(sts), 32'h00126);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
